// File: rtl/viterbi_link_k3.sv
// K=3 rate-1/2 convolutional encoder -> error-injecting channel -> 4-state hard-decision Viterbi decoder.
// Define VITERBI_ERR_INJ_EN to enable deterministic channel error injection.
module viterbi_link_k3 #(
    parameter int unsigned LATENCY  = 4105,
    parameter int unsigned TB_DEPTH = 64,
    parameter int unsigned PM_W     = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic encoder_i,
    input  logic enable_encoder_i,
    output logic decoder_o
);

    // Register-exchange survivors one bit longer than TB_DEPTH; the delay line makes up the rest.
    localparam int unsigned DEPTH = TB_DEPTH + 1;
    localparam int unsigned DLY   = LATENCY - DEPTH;

    logic            d;
    logic [1:0]      s;
    logic [1:0]      enc_pair;
    logic [1:0]      rx;
    logic [31:0]     word_ct;
    logic [1:0]      err_inj;
    logic [31:0]     error_counter;
    logic [32:0]     ec_sum;

    logic [PM_W-1:0]  pm      [4];
    logic [PM_W-1:0]  pm_nxt  [4];
    logic [1:0]       pred    [4];
    logic [DEPTH-1:0] paths   [4];
    logic [1:0]       best;
    logic             dec_raw;
    logic [DLY-1:0]   dly;

    assign d = encoder_i & enable_encoder_i;

`ifdef VITERBI_ERR_INJ_EN
    assign err_inj = (word_ct[3:0] == 4'hF) ? (word_ct[4] ? 2'b10 : 2'b01) : 2'b00;
`else
    assign err_inj = 2'b00;
`endif

    assign rx     = enc_pair ^ err_inj;
    assign ec_sum = {1'b0, error_counter} + 33'(err_inj[1]) + 33'(err_inj[0]);

    function automatic logic [1:0] branch_metric(input logic [1:0] r, input logic [1:0] p,
                                                 input logic b);
        logic [1:0] x;
        x = r ^ {b ^ p[1] ^ p[0], b ^ p[0]};
        return {1'b0, x[1]} + {1'b0, x[0]};
    endfunction

    function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a, input logic [1:0] b);
        logic [PM_W:0] sum;
        sum = {1'b0, a} + {{(PM_W-1){1'b0}}, b};
        return sum[PM_W] ? '1 : sum[PM_W-1:0];
    endfunction

    // Predecessors of state {b,s1} are {s1,0} and {s1,1}; a tie keeps the lower one.
    always_comb begin
        logic [1:0]      st;
        logic [PM_W-1:0] m0;
        logic [PM_W-1:0] m1;
        logic            all_msb;
        st      = '0;
        m0      = '0;
        m1      = '0;
        all_msb = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            st        = 2'(i);
            m0        = sat_add(pm[{st[0], 1'b0}], branch_metric(rx, {st[0], 1'b0}, st[1]));
            m1        = sat_add(pm[{st[0], 1'b1}], branch_metric(rx, {st[0], 1'b1}, st[1]));
            pred[i]   = {st[0], (m1 < m0)};
            pm_nxt[i] = (m1 < m0) ? m1 : m0;
            all_msb   = all_msb & pm_nxt[i][PM_W-1];
        end
        if (all_msb) begin
            for (int unsigned i = 0; i < 4; i++) begin
                pm_nxt[i][PM_W-1] = 1'b0;
            end
        end
    end

    always_comb begin
        best = 2'd0;
        for (int unsigned i = 1; i < 4; i++) begin
            if (pm[i] < pm[best]) begin
                best = 2'(i);
            end
        end
    end

    assign dec_raw   = paths[best][DEPTH-1];
    assign decoder_o = dly[DLY-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            s             <= '0;
            enc_pair      <= '0;
            word_ct       <= '0;
            error_counter <= '0;
            pm[0]         <= '0;
            for (int unsigned i = 1; i < 4; i++) begin
                pm[i] <= '1;
            end
            for (int unsigned i = 0; i < 4; i++) begin
                paths[i] <= '0;
            end
            dly <= '0;
        end else begin
            enc_pair      <= {d ^ s[1] ^ s[0], d ^ s[0]};
            s             <= {d, s[1]};
            word_ct       <= word_ct + 32'(enable_encoder_i);
            error_counter <= ec_sum[32] ? '1 : ec_sum[31:0];
            for (int unsigned i = 0; i < 4; i++) begin
                pm[i]    <= pm_nxt[i];
                paths[i] <= {paths[pred[i]][DEPTH-2:0], 1'(i >> 1)};
            end
            dly <= {dly[DLY-2:0], dec_raw};
        end
    end

endmodule

// File: tb/tb_viterbi_link_k3.sv
// Scoreboard bench for viterbi_link_k3: expected output is the masked input stream delayed by LATENCY.
module tb_viterbi_link_k3;

    localparam int unsigned LAT = 4105;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic encoder_i = 1'b0;
    logic enable_encoder_i = 1'b0;
    logic decoder_o;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    bit          expq[$];

    always #5 clk = ~clk;

    viterbi_link_k3 #(.LATENCY(LAT), .TB_DEPTH(64), .PM_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .encoder_i(encoder_i),
        .enable_encoder_i(enable_encoder_i),
        .decoder_o(decoder_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] err_model(input int unsigned wc);
`ifdef VITERBI_ERR_INJ_EN
        if (wc % 16 == 15) return ((wc / 16) % 2 == 1) ? 2'b10 : 2'b01;
        return 2'b00;
`else
        return 2'b00;
`endif
    endfunction

    // Monitor: compares every cycle against the reference stream and counter model.
    initial begin
        int unsigned ncyc = 0;
        int unsigned wc   = 0;
        int unsigned ec   = 0;
        logic [1:0]  perr = 2'b00;
        bit          e;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                expq.delete();
                ncyc = 0;
                wc   = 0;
                ec   = 0;
                perr = 2'b00;
                check("reset_decoder_o", 32'(decoder_o), 32'd0);
                check("reset_word_ct", dut.word_ct, 32'd0);
                check("reset_error_counter", dut.error_counter, 32'd0);
            end else begin
                ec   = ec + 32'(perr[1]) + 32'(perr[0]);
                wc   = wc + 32'(enable_encoder_i);
                perr = err_model(wc);
                e    = 1'b0;
                if (ncyc >= LAT) begin
                    if (expq.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL scoreboard_empty: got 0 entries expected >0 at %0t", $time);
                    end else begin
                        e = expq.pop_front();
                    end
                end
                check("decoder_o", 32'(decoder_o), 32'(e));
                check("err_inj", 32'(dut.err_inj), 32'(perr));
                check("word_ct", dut.word_ct, wc);
                check("error_counter", dut.error_counter, ec);
                ncyc++;
            end
        end
    end

    task automatic drive(input bit b, input bit en);
        @(negedge clk);
        rst              = 1'b0;
        encoder_i        = b;
        enable_encoder_i = en;
        expq.push_back(b & en);
    endtask

    task automatic hold_reset(input int unsigned n);
        repeat (n) begin
            @(negedge clk);
            rst              = 1'b1;
            encoder_i        = 1'($urandom);
            enable_encoder_i = 1'($urandom);
        end
    endtask

    initial begin
        logic [10:0] pat;
        pat = 11'b10011000111;

        // All-zero stream
        hold_reset(10);
        repeat (5000) drive(1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("word_ct_after_5000", dut.word_ct, 32'd5000);

        // Single impulse
        hold_reset(2);
        drive(1'b1, 1'b1);
        repeat (LAT + 50) drive(1'b0, 1'b1);

        // Pattern twice, random tail
        hold_reset(2);
        for (int r = 0; r < 2; r++) begin
            for (int i = 10; i >= 0; i--) drive(pat[i], 1'b1);
        end
        for (int i = 22; i < 256; i++) drive(1'($urandom), 1'b1);
        @(posedge clk);
        #1;
        check("word_ct_after_256", dut.word_ct, 32'd256);
`ifdef VITERBI_ERR_INJ_EN
        check("error_counter_after_256", dut.error_counter, 32'd16);
`else
        check("error_counter_after_256", dut.error_counter, 32'd0);
`endif
        repeat (LAT + 10) drive(1'($urandom), 1'b1);

        // Long runs with an enable gap
        hold_reset(2);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 200; c++) begin
                drive(c < 100, !(r == 0 && c >= 50 && c <= 59));
            end
        end
        repeat (LAT + 10) drive(1'($urandom), 1'($urandom));

        // Mid-stream reset, then random traffic
        hold_reset(2);
        repeat (3000) drive(1'($urandom), 1'($urandom_range(0, 7) != 0));
        hold_reset(1);
        repeat (1000 + LAT + 10) drive(1'($urandom), 1'b1);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
